// File: rtl/alu_ctl_pipe.sv
// ALU control decode with a one-entry ID/EX slot and multi-cycle MUL/DIV occupancy.
// Define ALU_CTL_MULDIV_EN to decode RV32M and build the occupancy counter.
module alu_ctl_pipe #(
    parameter int ALU_SEL_W = 6,
    parameter int MUL_CYC   = 3,
    parameter int DIV_CYC   = 33
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           alu_op,
    input  logic [6:0]           funct7,
    input  logic [2:0]           funct3,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ALU_SEL_W-1:0] alu_ctl,
    output logic                 illegal,
    output logic                 mc_busy
);

    if (ALU_SEL_W < 5 || MUL_CYC < 1 || DIV_CYC < 1) begin : g_bad_param
        $error("alu_ctl_pipe: ALU_SEL_W must be >= 5, MUL_CYC and DIV_CYC >= 1");
    end

    typedef enum logic [4:0] {
        C_ERR = 5'd0,  C_ADD = 5'd1,  C_SUB = 5'd2,  C_AND = 5'd3,  C_OR = 5'd4,
        C_XOR = 5'd5,  C_SLL = 5'd6,  C_SRL = 5'd7,  C_SRA = 5'd8,  C_SLT = 5'd9,
        C_SLTU = 5'd10, C_BNE = 5'd11, C_BLT = 5'd12, C_BGE = 5'd13, C_BLTU = 5'd14,
        C_BGEU = 5'd15, C_MUL = 5'd16, C_MULH = 5'd17, C_MULHSU = 5'd18, C_MULHU = 5'd19,
        C_DIV = 5'd20, C_DIVU = 5'd21, C_REM = 5'd22, C_REMU = 5'd23
    } code_e;

    code_e w_code;
    logic  w_load;
    logic  r_full;
    logic  [ALU_SEL_W-1:0] r_ctl;
    logic  r_ill;

    always_comb begin
        w_code = C_ERR;
        case (alu_op)
            2'b00: w_code = C_ADD;
            2'b01: begin
                case (funct3)
                    3'b000:  w_code = C_SUB;
                    3'b001:  w_code = C_BNE;
                    3'b100:  w_code = C_BLT;
                    3'b101:  w_code = C_BGE;
                    3'b110:  w_code = C_BLTU;
                    3'b111:  w_code = C_BGEU;
                    default: w_code = C_ERR;
                endcase
            end
            2'b10: begin
                if (funct7 == 7'b0000000) begin
                    case (funct3)
                        3'b000:  w_code = C_ADD;
                        3'b001:  w_code = C_SLL;
                        3'b010:  w_code = C_SLT;
                        3'b011:  w_code = C_SLTU;
                        3'b100:  w_code = C_XOR;
                        3'b101:  w_code = C_SRL;
                        3'b110:  w_code = C_OR;
                        default: w_code = C_AND;
                    endcase
                end else if (funct7 == 7'b0100000) begin
                    if (funct3 == 3'b000)      w_code = C_SUB;
                    else if (funct3 == 3'b101) w_code = C_SRA;
                end
`ifdef ALU_CTL_MULDIV_EN
                else if (funct7 == 7'b0000001) begin
                    case (funct3)
                        3'b000:  w_code = C_MUL;
                        3'b001:  w_code = C_MULH;
                        3'b010:  w_code = C_MULHSU;
                        3'b011:  w_code = C_MULHU;
                        3'b100:  w_code = C_DIV;
                        3'b101:  w_code = C_DIVU;
                        3'b110:  w_code = C_REM;
                        default: w_code = C_REMU;
                    endcase
                end
`endif
            end
            default: begin
                // OP-IMM: funct7 only matters for the shift encodings
                case (funct3)
                    3'b000: w_code = C_ADD;
                    3'b010: w_code = C_SLT;
                    3'b011: w_code = C_SLTU;
                    3'b100: w_code = C_XOR;
                    3'b110: w_code = C_OR;
                    3'b111: w_code = C_AND;
                    3'b001: if (funct7 == 7'b0000000) w_code = C_SLL;
                    default: begin
                        if (funct7 == 7'b0000000)      w_code = C_SRL;
                        else if (funct7 == 7'b0100000) w_code = C_SRA;
                    end
                endcase
            end
        endcase
    end

    assign w_load    = in_valid & in_ready & ~flush;
    assign out_valid = r_full & ~mc_busy;
    assign in_ready  = ~mc_busy & (~out_valid | out_ready);
    assign alu_ctl   = r_ctl;
    assign illegal   = r_ill;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_full <= 1'b0;
            r_ctl  <= '0;
            r_ill  <= 1'b0;
        end else if (flush) begin
            r_full <= 1'b0;
        end else if (w_load) begin
            r_full <= 1'b1;
            r_ctl  <= ALU_SEL_W'(w_code);
            r_ill  <= (w_code == C_ERR);
        end else if (out_valid & out_ready) begin
            r_full <= 1'b0;
        end
    end

`ifdef ALU_CTL_MULDIV_EN
    localparam int MAX_CYC = (MUL_CYC > DIV_CYC) ? MUL_CYC : DIV_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_lat;

    // Remaining occupancy after the accept edge; zero means result is ready
    always_comb begin
        w_lat = '0;
        if (w_code >= C_DIV)      w_lat = CNT_W'(DIV_CYC - 1);
        else if (w_code >= C_MUL) w_lat = CNT_W'(MUL_CYC - 1);
    end

    always_ff @(posedge clk) begin
        if (reset || flush)    r_cnt <= '0;
        else if (w_load)       r_cnt <= w_lat;
        else if (r_cnt != '0)  r_cnt <= r_cnt - 1'b1;
    end

    assign mc_busy = (r_cnt != '0);
`else
    assign mc_busy = 1'b0;
`endif

endmodule

// File: tb/tb_alu_ctl_pipe.sv
// Self-checking bench for alu_ctl_pipe: decode table, hand sequences, randomized run vs model.
module tb_alu_ctl_pipe;
    localparam int W       = 6;
    localparam int MUL_CYC = 3;
    localparam int DIV_CYC = 33;
`ifdef ALU_CTL_MULDIV_EN
    localparam int MULDIV = 1;
`else
    localparam int MULDIV = 0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;
    logic [1:0] alu_op = '0;
    logic [6:0] funct7 = '0;
    logic [2:0] funct3 = '0;
    logic in_ready, out_valid, illegal, mc_busy;
    logic [W-1:0] alu_ctl;

    alu_ctl_pipe #(.ALU_SEL_W(W), .MUL_CYC(MUL_CYC), .DIV_CYC(DIV_CYC)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .funct7(funct7), .funct3(funct3), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .alu_ctl(alu_ctl),
        .illegal(illegal), .mc_busy(mc_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // model of the slot: occupancy, result, and the cycle its result becomes visible
    int cyc = 0;
    bit m_full = 0;
    int m_ctl = 0;
    bit m_ill = 0;
    int m_rdy = 0;

    typedef struct {
        logic [1:0] op;
        logic [6:0] f7;
        logic [2:0] f3;
        int         ctl;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t mk(int op, int f7, int f3, int ctl);
        vec_t v;
        v.op = op[1:0]; v.f7 = f7[6:0]; v.f3 = f3[2:0]; v.ctl = ctl;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int ref_decode(logic [1:0] op, logic [6:0] f7, logic [2:0] f3);
        int r3[8];
        int i3[8];
        r3 = '{1, 6, 9, 10, 5, 7, 4, 3};
        i3 = '{1, 0, 9, 10, 5, 0, 4, 3};
        if (op == 2'b00) return 1;
        if (op == 2'b01) begin
            if (f3 == 0) return 2;
            if (f3 == 2 || f3 == 3) return 0;
            return 10 + ((f3 == 1) ? 1 : int'(f3) - 2);
        end
        if (op == 2'b10) begin
            if (f7 == 7'h00) return r3[f3];
            if (f7 == 7'h20) return (f3 == 0) ? 2 : (f3 == 5) ? 8 : 0;
            if (f7 == 7'h01 && MULDIV != 0) return 16 + int'(f3);
            return 0;
        end
        if (f3 == 1) return (f7 == 7'h00) ? 6 : 0;
        if (f3 == 5) return (f7 == 7'h00) ? 7 : (f7 == 7'h20) ? 8 : 0;
        return i3[f3];
    endfunction

    function automatic int ref_lat(int code);
        if (code >= 20) return DIV_CYC;
        if (code >= 16) return MUL_CYC;
        return 1;
    endfunction

    function automatic bit m_busy();
        return m_full && (cyc < m_rdy);
    endfunction

    task automatic check_outs();
        bit b, ov, ir;
        b  = m_busy();
        ov = m_full && !b;
        ir = !b && (!ov || out_ready);
        chk("out_valid", out_valid, ov);
        chk("mc_busy", mc_busy, b);
        chk("in_ready", in_ready, ir);
        chk("alu_ctl", alu_ctl, m_ctl);
        chk("illegal", illegal, m_ill);
    endtask

    // advance one clock, updating the model from the inputs sampled at that edge
    task automatic step();
        bit b, ov, ir, ld;
        int code;
        b    = m_busy();
        ov   = m_full && !b;
        ir   = !b && (!ov || out_ready);
        ld   = in_valid && ir && !flush;
        code = ref_decode(alu_op, funct7, funct3);
        @(posedge clk);
        cyc++;
        if (reset) begin
            m_full = 0; m_ctl = 0; m_ill = 0;
        end else if (flush) begin
            m_full = 0;
        end else if (ld) begin
            m_full = 1; m_ctl = code; m_ill = (code == 0);
            m_rdy  = cyc + ref_lat(code) - 1;
        end else if (ov && out_ready) begin
            m_full = 0;
        end
        #1;
        check_outs();
    endtask

    task automatic drive(int op, int f7, int f3);
        alu_op = op[1:0]; funct7 = f7[6:0]; funct3 = f3[2:0];
    endtask

    task automatic issue(vec_t v);
        int n;
        drive(v.op, v.f7, v.f3);
        in_valid = 1; out_ready = 1;
        n = 0;
        while (!in_ready && n < 200) begin step(); n++; end
        step();
        in_valid = 0;
        while (!out_valid && n < 200) begin step(); n++; end
        chk("issue_wait_bound", n < 200, 1);
    endtask

    initial begin
        int n;
        // decode table: {alu_op, funct7, funct3, expected alu_ctl (0 = illegal)}
        tbl.push_back(mk(0, 7'h55, 3, 1));
        tbl.push_back(mk(1, 0, 0, 2));   tbl.push_back(mk(1, 0, 1, 11));
        tbl.push_back(mk(1, 0, 4, 12));  tbl.push_back(mk(1, 0, 5, 13));
        tbl.push_back(mk(1, 0, 6, 14));  tbl.push_back(mk(1, 0, 7, 15));
        tbl.push_back(mk(1, 0, 2, 0));   tbl.push_back(mk(1, 0, 3, 0));
        tbl.push_back(mk(2, 0, 0, 1));   tbl.push_back(mk(2, 0, 1, 6));
        tbl.push_back(mk(2, 0, 2, 9));   tbl.push_back(mk(2, 0, 3, 10));
        tbl.push_back(mk(2, 0, 4, 5));   tbl.push_back(mk(2, 0, 5, 7));
        tbl.push_back(mk(2, 0, 6, 4));   tbl.push_back(mk(2, 0, 7, 3));
        tbl.push_back(mk(2, 7'h20, 0, 2)); tbl.push_back(mk(2, 7'h20, 5, 8));
        tbl.push_back(mk(2, 7'h20, 1, 0)); tbl.push_back(mk(2, 7'h40, 0, 0));
        tbl.push_back(mk(3, 7'h7f, 0, 1)); tbl.push_back(mk(3, 7'h33, 2, 9));
        tbl.push_back(mk(3, 0, 3, 10));  tbl.push_back(mk(3, 0, 4, 5));
        tbl.push_back(mk(3, 0, 6, 4));   tbl.push_back(mk(3, 0, 7, 3));
        tbl.push_back(mk(3, 0, 1, 6));   tbl.push_back(mk(3, 7'h20, 1, 0));
        tbl.push_back(mk(3, 0, 5, 7));   tbl.push_back(mk(3, 7'h20, 5, 8));
        tbl.push_back(mk(3, 7'h10, 5, 0));
        tbl.push_back(mk(2, 1, 0, MULDIV ? 16 : 0));
        tbl.push_back(mk(2, 1, 4, MULDIV ? 20 : 0));
        tbl.push_back(mk(2, 1, 7, MULDIV ? 23 : 0));

        // reset held two cycles
        step(); step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_alu_ctl", alu_ctl, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_mc_busy", mc_busy, 0);
        reset = 0;
        #1;
        chk("rst_in_ready", in_ready, 1);

        foreach (tbl[i]) begin
            issue(tbl[i]);
            chk("vec_ctl", alu_ctl, tbl[i].ctl);
            chk("vec_illegal", illegal, tbl[i].ctl == 0);
        end
        out_ready = 1;
        step();

        // sub then sra back-to-back
        drive(2, 7'h20, 0); in_valid = 1; out_ready = 1;
        step();
        chk("b2b_sub_valid", out_valid, 1);
        chk("b2b_sub_ctl", alu_ctl, 2);
        drive(2, 7'h20, 5);
        step();
        chk("b2b_sra_valid", out_valid, 1);
        chk("b2b_sra_ctl", alu_ctl, 8);
        in_valid = 0;
        step();
        chk("b2b_drain", out_valid, 0);

        // backpressure: slot full with bge, xor waits
        drive(1, 0, 5); in_valid = 1; out_ready = 0;
        step();
        drive(2, 0, 4);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("bp_in_ready", in_ready, 0);
            chk("bp_hold_ctl", alu_ctl, 13);
        end
        out_ready = 1;
        step();
        chk("bp_second_ctl", alu_ctl, 5);
        chk("bp_second_valid", out_valid, 1);
        in_valid = 0;
        step();

        // flush drops the slot and any request presented with it
        drive(0, 0, 0); in_valid = 1; out_ready = 0;
        step();
        drive(2, 7'h20, 0); flush = 1;
        step();
        chk("fl_valid", out_valid, 0);
        chk("fl_hold_ctl", alu_ctl, 1);
        chk("fl_in_ready", in_ready, 1);
        flush = 0; in_valid = 0;
        step();
        chk("fl_not_taken", out_valid, 0);

        if (MULDIV != 0) begin
            // div occupancy
            drive(2, 1, 4); in_valid = 1; out_ready = 1;
            step();
            in_valid = 0;
            n = 0;
            while (mc_busy && n < 100) begin
                chk("div_in_ready", in_ready, 0);
                step(); n++;
            end
            chk("div_busy_cycles", n, DIV_CYC - 1);
            chk("div_valid", out_valid, 1);
            chk("div_ctl", alu_ctl, 20);
            step();
            // flush on cycle 10 of a div
            in_valid = 1;
            step();
            in_valid = 0;
            for (int k = 1; k < 10; k++) step();
            drive(2, 0, 0); in_valid = 1; flush = 1;
            step();
            chk("div_fl_valid", out_valid, 0);
            chk("div_fl_busy", mc_busy, 0);
            chk("div_fl_in_ready", in_ready, 1);
            flush = 0; in_valid = 0;
            step();
            chk("div_fl_not_taken", out_valid, 0);
        end

        // randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            int sel;
            sel = $urandom_range(0, 3);
            drive($urandom_range(0, 3),
                  (sel == 0) ? 0 : (sel == 1) ? 7'h20 : (sel == 2) ? 1 : $urandom_range(0, 127),
                  $urandom_range(0, 7));
            in_valid  = ($urandom_range(0, 9) < 6);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 99) < 4);
            reset     = ($urandom_range(0, 299) == 0);
            step();
        end
        reset = 0; flush = 0; in_valid = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
